// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_write_sequencer : tick-timed HD44780 8-bit parallel write cycle engine
// Revision 1.0
// ---------------------------------------------------------------------------
module lcd_write_sequencer #(
    parameter int unsigned SETUP_TICKS     = 1,
    parameter int unsigned E_HIGH_TICKS    = 2,
    parameter int unsigned HOLD_TICKS      = 1,
    parameter int unsigned CMD_WAIT_TICKS  = 20,
    parameter int unsigned DATA_WAIT_TICKS = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       TimerIndicator,
    output logic       EnableCount,
    output logic       DisableCount,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_E_HIGH = 3'd2,
        S_HOLD   = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] c_setup_last = 8'(SETUP_TICKS - 1);
    localparam logic [7:0] c_ehigh_last = 8'(E_HIGH_TICKS - 1);
    localparam logic [7:0] c_hold_last  = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] c_cmd_last   = 8'(CMD_WAIT_TICKS - 1);
    localparam logic [7:0] c_data_last  = 8'(DATA_WAIT_TICKS - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] wait_last_q;
    logic [7:0] w_last;
    logic       w_slow_cmd;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    assign w_slow_cmd = !req_rs && (req_data[7:2] == 6'd0) && (req_data != 8'd0);
    assign LCD_RW     = 1'b0;

    always_comb begin
        w_last = c_setup_last;
        case (state_q)
            S_SETUP:  w_last = c_setup_last;
            S_E_HIGH: w_last = c_ehigh_last;
            S_HOLD:   w_last = c_hold_last;
            S_WAIT:   w_last = wait_last_q;
            default:  w_last = c_setup_last;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            wait_last_q  <= 8'd0;
            EnableCount  <= 1'b0;
            DisableCount <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            LCD_RS       <= 1'b0;
            LCD_E        <= 1'b0;
            LCD_DB       <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q      <= S_SETUP;
                        cnt_q        <= 8'd0;
                        wait_last_q  <= w_slow_cmd ? c_cmd_last : c_data_last;
                        LCD_RS       <= req_rs;
                        LCD_DB       <= req_data;
                        busy         <= 1'b1;
                        EnableCount  <= 1'b1;
                        DisableCount <= 1'b0;
                    end
                end
                S_SETUP, S_E_HIGH, S_HOLD, S_WAIT: begin
                    if (TimerIndicator) begin
                        if (cnt_q == w_last) begin
                            cnt_q <= 8'd0;
                            case (state_q)
                                S_SETUP: begin
                                    state_q <= S_E_HIGH;
                                    LCD_E   <= 1'b1;
                                end
                                S_E_HIGH: begin
                                    state_q <= S_HOLD;
                                    LCD_E   <= 1'b0;
                                end
                                S_HOLD:  state_q <= S_WAIT;
                                default: begin
                                    state_q <= S_DONE;
                                    done    <= 1'b1;
                                end
                            endcase
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    EnableCount  <= 1'b0;
                    DisableCount <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    LCD_E        <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    EnableCount  <= 1'b0;
                    DisableCount <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
`default_nettype none
// Directed bench for lcd_write_sequencer: default instance plus a SETUP=3, E_HIGH=1 instance.
module tb_lcd_write_sequencer;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       TimerIndicator = 1'b0;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;

    logic       EnableCount, DisableCount, busy, done, LCD_RS, LCD_RW, LCD_E;
    logic [7:0] LCD_DB;
    logic       en2, dis2, busy2, done2, rs2, rw2, e2;
    logic [7:0] db2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lcd_write_sequencer dut (
        .clock(clock), .rst(rst), .TimerIndicator(TimerIndicator),
        .EnableCount(EnableCount), .DisableCount(DisableCount),
        .req(req), .req_rs(req_rs), .req_data(req_data),
        .busy(busy), .done(done), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_E(LCD_E), .LCD_DB(LCD_DB)
    );

    lcd_write_sequencer #(.SETUP_TICKS(3), .E_HIGH_TICKS(1)) dut2 (
        .clock(clock), .rst(rst), .TimerIndicator(TimerIndicator),
        .EnableCount(en2), .DisableCount(dis2),
        .req(req), .req_rs(req_rs), .req_data(req_data),
        .busy(busy2), .done(done2), .LCD_RS(rs2), .LCD_RW(rw2),
        .LCD_E(e2), .LCD_DB(db2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        TimerIndicator = 1'b1;
        step();
        TimerIndicator = 1'b0;
    endtask

    // Issues one write, then ticks with a gap cycle between ticks until done.
    task automatic do_write(input logic rs, input logic [7:0] d, output int nt, output int e_ticks);
        logic seen;
        seen = 1'b0;
        nt = 0;
        e_ticks = 0;
        req_rs = rs; req_data = d; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (LCD_E) e_ticks++;
            tick();
            nt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) nt = -1;
        step();
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        logic [14:0] exp_v;
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        rst = 1'b0; req = 1'b1; req_rs = 1'b1; req_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            TimerIndicator = (i % 2 == 0);
            step();
            obs = {busy, done, LCD_E, DisableCount, EnableCount, LCD_RS, LCD_RW, LCD_DB};
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_outputs cyc%0d: got %h want %h", i, obs, exp_v); end
            checks++; if ({e2, busy2, dis2} !== 3'b001) begin errors++; $display("FAIL reset_dut2 cyc%0d: got %b want 001", i, {e2, busy2, dis2}); end
        end
        TimerIndicator = 1'b0; req = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        #2 rst = 1'b1;
        step();
        checks++; if ({busy, DisableCount} !== 2'b01) begin errors++; $display("FAIL reset_release: got %b want 01", {busy, DisableCount}); end
    endtask

    task automatic test_data_write();
        req_rs = 1'b1; req_data = 8'h41; req = 1'b1;
        step();
        req = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dw_busy: got %b want 1", busy); end
        checks++; if ({LCD_RS, LCD_DB} !== 9'h141) begin errors++; $display("FAIL dw_bus: got %h want 141", {LCD_RS, LCD_DB}); end
        checks++; if ({DisableCount, EnableCount} !== 2'b01) begin errors++; $display("FAIL dw_timer: got %b want 01", {DisableCount, EnableCount}); end
        checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL dw_e_setup: got %b want 0", LCD_E); end
        tick();
        checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL dw_e_rise: got %b want 1", LCD_E); end
        step();
        checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL dw_e_hold_notick: got %b want 1", LCD_E); end
        tick();
        checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL dw_e_tick2: got %b want 1", LCD_E); end
        tick();
        checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL dw_e_fall: got %b want 0", LCD_E); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dw_done_early: got %b want 0", done); end
        tick();
        checks++; if ({done, busy, DisableCount} !== 3'b110) begin errors++; $display("FAIL dw_done: got %b want 110", {done, busy, DisableCount}); end
        step();
        checks++; if ({done, busy, DisableCount, EnableCount} !== 4'b0010) begin errors++; $display("FAIL dw_idle: got %b want 0010", {done, busy, DisableCount, EnableCount}); end
        checks++; if ({LCD_RS, LCD_DB} !== 9'h141) begin errors++; $display("FAIL dw_bus_hold: got %h want 141", {LCD_RS, LCD_DB}); end
    endtask

    task automatic test_commands();
        int nt, et;
        do_write(1'b0, 8'h01, nt, et);
        checks++; if (nt !== 24) begin errors++; $display("FAIL cmd_clear_ticks: got %0d want 24", nt); end
        checks++; if (et !== 2) begin errors++; $display("FAIL cmd_clear_e_ticks: got %0d want 2", et); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cmd_done_width: got %b want 0", done); end
        do_write(1'b0, 8'h03, nt, et);
        checks++; if (nt !== 24) begin errors++; $display("FAIL cmd_home_ticks: got %0d want 24", nt); end
        do_write(1'b0, 8'h38, nt, et);
        checks++; if (nt !== 5) begin errors++; $display("FAIL cmd_func_ticks: got %0d want 5", nt); end
        do_write(1'b0, 8'h00, nt, et);
        checks++; if (nt !== 5) begin errors++; $display("FAIL cmd_zero_ticks: got %0d want 5", nt); end
        do_write(1'b1, 8'h01, nt, et);
        checks++; if (nt !== 5) begin errors++; $display("FAIL data01_ticks: got %0d want 5", nt); end
        checks++; if ({LCD_RS, LCD_DB} !== 9'h101) begin errors++; $display("FAIL data01_bus: got %h want 101", {LCD_RS, LCD_DB}); end
    endtask

    task automatic test_busy_reject();
        int dn;
        dn = 0;
        req_rs = 1'b1; req_data = 8'h66; req = 1'b1;
        step();
        req = 1'b0;
        tick();
        checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL br_e_high: got %b want 1", LCD_E); end
        req_data = 8'h55; req = 1'b1;
        step();
        step();
        req = 1'b0;
        checks++; if (LCD_DB !== 8'h66) begin errors++; $display("FAIL br_db_mid: got %h want 66", LCD_DB); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dn++;
            step();
            if (done) dn++;
        end
        checks++; if (dn !== 1) begin errors++; $display("FAIL br_done_count: got %0d want 1", dn); end
        checks++; if ({busy, LCD_DB} !== 9'h066) begin errors++; $display("FAIL br_final: got %h want 066", {busy, LCD_DB}); end
    endtask

    task automatic test_back_to_back();
        req_rs = 1'b1; req_data = 8'h48; req = 1'b1;
        step();
        req_data = 8'h49;
        checks++; if (LCD_DB !== 8'h48) begin errors++; $display("FAIL b2b_first_db: got %h want 48", LCD_DB); end
        for (int i = 0; i < 4; i++) begin
            tick();
            step();
        end
        tick();
        checks++; if ({done, DisableCount} !== 2'b10) begin errors++; $display("FAIL b2b_done1: got %b want 10", {done, DisableCount}); end
        step();
        checks++; if ({busy, DisableCount, LCD_DB} !== {2'b01, 8'h48}) begin errors++; $display("FAIL b2b_idle_gap: got %h want %h", {busy, DisableCount, LCD_DB}, {2'b01, 8'h48}); end
        step();
        req = 1'b0;
        checks++; if ({busy, DisableCount, LCD_DB} !== {2'b10, 8'h49}) begin errors++; $display("FAIL b2b_second_accept: got %h want %h", {busy, DisableCount, LCD_DB}, {2'b10, 8'h49}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            step();
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done); end
        step();
    endtask

    task automatic test_async_reset();
        req_rs = 1'b0; req_data = 8'h38; req = 1'b1;
        step();
        req = 1'b0;
        tick();
        checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL ar_e_before: got %b want 1", LCD_E); end
        #3 rst = 1'b0;
        #1;
        checks++; if ({LCD_E, busy, DisableCount} !== 3'b001) begin errors++; $display("FAIL ar_async: got %b want 001", {LCD_E, busy, DisableCount}); end
        #2 rst = 1'b1;
        step();
        checks++; if ({LCD_E, busy, DisableCount, LCD_DB} !== {3'b001, 8'h00}) begin errors++; $display("FAIL ar_after: got %h want %h", {LCD_E, busy, DisableCount, LCD_DB}, {3'b001, 8'h00}); end
        tick();
        checks++; if ({LCD_E, busy} !== 2'b00) begin errors++; $display("FAIL ar_idle_tick: got %b want 00", {LCD_E, busy}); end
    endtask

    task automatic test_params();
        for (int i = 0; i < 5; i++) begin
            tick();
            step();
        end
        checks++; if ({busy2, e2, dis2} !== 3'b001) begin errors++; $display("FAIL p_idle: got %b want 001", {busy2, e2, dis2}); end
        req_rs = 1'b1; req_data = 8'h7A; req = 1'b1; TimerIndicator = 1'b1;
        step();
        req = 1'b0; TimerIndicator = 1'b0;
        checks++; if ({busy2, rs2, db2} !== {2'b11, 8'h7A}) begin errors++; $display("FAIL p_accept: got %h want %h", {busy2, rs2, db2}, {2'b11, 8'h7A}); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++; if (e2 !== (k == 3)) begin errors++; $display("FAIL p_e_tick%0d: got %b want %b", k, e2, (k == 3)); end
            checks++; if (done2 !== (k == 6)) begin errors++; $display("FAIL p_done_tick%0d: got %b want %b", k, done2, (k == 6)); end
            step();
        end
        checks++; if ({busy2, done2, dis2, rw2} !== 4'b0010) begin errors++; $display("FAIL p_end: got %b want 0010", {busy2, done2, dis2, rw2}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_data_write();
        test_commands();
        test_busy_reject();
        test_back_to_back();
        test_async_reset();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
